// File: rtl/rename_if.sv
// Rename-stage types and the decode/issue/commit bundle seen by the rename stage.
// The slave modport is the rename side; the master modport is its environment.
package rename_pkg;
    localparam int PRFSIZE      = 64;
    localparam int NPREG        = PRFSIZE;
    localparam int ARFSIZE      = 32;
    localparam int NAREG        = ARFSIZE;
    localparam int ID_BITS      = 32;
    localparam int PREG_ID_BITS = $clog2(NPREG);
    localparam int AREG_ID_BITS = $clog2(NAREG);

    typedef struct packed {
        logic [31:0]             pc;
        logic [AREG_ID_BITS-1:0] rs1;
        logic [AREG_ID_BITS-1:0] rs2;
        logic [AREG_ID_BITS-1:0] rd;
        logic                    rs1_valid;
        logic                    rs2_valid;
        logic                    rd_valid;
        logic [2:0]              fu;
        logic [3:0]              op;
        logic [31:0]             imm;
    } si_t;

    typedef struct packed {
        logic [ID_BITS-1:0]      id;
        logic [PREG_ID_BITS-1:0] prs1;
        logic [PREG_ID_BITS-1:0] prs2;
        logic                    prs1_renammed;
        logic                    prs2_renammed;
        logic [PREG_ID_BITS-1:0] prd;
        si_t                     si;
    } di_t;
endpackage

interface rename_if;
    rename_pkg::si_t                           si_i;
    logic                                      si_i_valid;
    logic                                      si_i_ready;
    rename_pkg::di_t                           di_o;
    logic                                      di_o_valid;
    logic                                      di_o_ready;
    logic                                      commit_valid_i;
    logic [rename_pkg::PREG_ID_BITS-1:0]       commit_prd_i;
    logic [rename_pkg::AREG_ID_BITS-1:0]       commit_ard_i;

    modport slave (
        input  si_i, si_i_valid, di_o_ready, commit_valid_i, commit_prd_i, commit_ard_i,
        output si_i_ready, di_o, di_o_valid
    );
    modport master (
        output si_i, si_i_valid, di_o_ready, commit_valid_i, commit_prd_i, commit_ard_i,
        input  si_i_ready, di_o, di_o_valid
    );
endinterface

// File: rtl/rename.sv
// Rename stage: allocates destinations from a circular free list, maps sources through the
// rename table and returns registers on commit. Option: RENAME_FREELIST_BYPASS_EN.
module rename
    import rename_pkg::*;
(
    input  logic    clk,
    input  logic    rstn,
    rename_if.slave bus
);
    typedef struct packed {
        logic                    valid;
        logic [PREG_ID_BITS-1:0] prd;
    } map_t;

    localparam logic [PREG_ID_BITS:0] COUNT_FULL = (PREG_ID_BITS+1)'(NPREG);

    map_t                    map_q [NAREG];
    map_t                    map_d [NAREG];
    map_t                    map_clr_s [NAREG];
    logic [PREG_ID_BITS-1:0] fl_q [NPREG];
    logic [PREG_ID_BITS-1:0] fl_d [NPREG];
    logic [PREG_ID_BITS-1:0] head_q, head_d, tail_q, tail_d;
    logic [PREG_ID_BITS:0]   count_q, count_d;
    logic [ID_BITS-1:0]      id_q, id_d;
    di_t                     di_q, di_d;
    logic                    di_valid_q, di_valid_d;

    si_t                     si_s;
    logic                    need_alloc_s, byp_s, ready_s, accept_s, alloc_s;
    logic                    use_byp_s, take_head_s, free_ok_s, fl_write_s;
    logic [PREG_ID_BITS-1:0] alloc_prd_s;

    function automatic logic [PREG_ID_BITS-1:0] ptr_inc(input logic [PREG_ID_BITS-1:0] p);
        if (p == PREG_ID_BITS'(NPREG-1)) begin
            return '0;
        end else begin
            return p + PREG_ID_BITS'(1);
        end
    endfunction

    // Handshake and allocation decisions for this cycle.
    always_comb begin
        si_s         = bus.si_i;
        need_alloc_s = si_s.rd_valid && (si_s.rd != '0);
`ifdef RENAME_FREELIST_BYPASS_EN
        byp_s        = (count_q == '0) && bus.commit_valid_i;
`else
        byp_s        = 1'b0;
`endif
        ready_s      = (!di_valid_q || bus.di_o_ready) &&
                       (!need_alloc_s || (count_q != '0) || byp_s);
        accept_s     = bus.si_i_valid && ready_s;
        alloc_s      = accept_s && need_alloc_s;
        // An empty list can only allocate through the bypass, which consumes the commit directly.
        use_byp_s    = alloc_s && (count_q == '0);
        take_head_s  = alloc_s && !use_byp_s;
        free_ok_s    = bus.commit_valid_i && (count_q != COUNT_FULL);
        fl_write_s   = free_ok_s && !use_byp_s;
        alloc_prd_s  = use_byp_s ? bus.commit_prd_i : fl_q[head_q];
    end

    // Free-list FIFO pointers, storage and occupancy.
    always_comb begin
        fl_d   = fl_q;
        head_d = take_head_s ? ptr_inc(head_q) : head_q;
        if (fl_write_s) begin
            fl_d[tail_q] = bus.commit_prd_i;
            tail_d       = ptr_inc(tail_q);
        end else begin
            tail_d       = tail_q;
        end
        case ({fl_write_s, take_head_s})
            2'b10:   count_d = count_q + (PREG_ID_BITS+1)'(1);
            2'b01:   count_d = count_q - (PREG_ID_BITS+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Map table: commit clears a matching mapping, then a same-cycle rename write overrides it.
    always_comb begin
        map_clr_s = map_q;
        if (bus.commit_valid_i && (bus.commit_ard_i != '0) &&
            map_q[bus.commit_ard_i].valid && (map_q[bus.commit_ard_i].prd == bus.commit_prd_i)) begin
            map_clr_s[bus.commit_ard_i].valid = 1'b0;
        end else begin
            map_clr_s[bus.commit_ard_i] = map_q[bus.commit_ard_i];
        end
        map_d = map_clr_s;
        if (alloc_s) begin
            map_d[si_s.rd] = {1'b1, alloc_prd_s};
        end else begin
            map_d[si_s.rd] = map_clr_s[si_s.rd];
        end
    end

    // Output register: load on accept, drop when consumed, otherwise hold under backpressure.
    always_comb begin
        di_d       = di_q;
        di_valid_d = di_valid_q;
        id_d       = id_q;
        if (accept_s) begin
            di_valid_d         = 1'b1;
            di_d.id            = id_q;
            di_d.si            = si_s;
            di_d.prs1          = map_clr_s[si_s.rs1].prd;
            di_d.prs2          = map_clr_s[si_s.rs2].prd;
            di_d.prs1_renammed = si_s.rs1_valid && (si_s.rs1 != '0) && map_clr_s[si_s.rs1].valid;
            di_d.prs2_renammed = si_s.rs2_valid && (si_s.rs2 != '0) && map_clr_s[si_s.rs2].valid;
            di_d.prd           = alloc_s ? alloc_prd_s : '0;
            id_d               = id_q + ID_BITS'(1);
        end else if (bus.di_o_ready) begin
            di_valid_d = 1'b0;
        end else begin
            di_valid_d = di_valid_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NAREG; i++) map_q[i] <= '0;
            for (int i = 0; i < NPREG; i++) fl_q[i] <= PREG_ID_BITS'(i);
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= COUNT_FULL;
            id_q       <= '0;
            di_q       <= '0;
            di_valid_q <= 1'b0;
        end else begin
            map_q      <= map_d;
            fl_q       <= fl_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            id_q       <= id_d;
            di_q       <= di_d;
            di_valid_q <= di_valid_d;
        end
    end

    assign bus.si_i_ready = ready_s;
    assign bus.di_o       = di_q;
    assign bus.di_o_valid = di_valid_q;

    rename_chk u_chk (
        .clk            (clk),
        .rstn           (rstn),
        .commit_valid_i (bus.commit_valid_i),
        .count_q        (count_q)
    );
endmodule

// Flags a commit that tries to free a register while the free list is already full.
module rename_chk
    import rename_pkg::*;
(
    input logic                    clk,
    input logic                    rstn,
    input logic                    commit_valid_i,
    input logic [PREG_ID_BITS:0]   count_q
);
    // Overflowing free is dropped by the datapath; report it here.
    always_ff @(posedge clk) begin
        if (rstn && commit_valid_i) begin
            assert (count_q != (PREG_ID_BITS+1)'(NPREG));
        end
    end
endmodule
